// File: rtl/sequencer_transport.sv
// sequencer_transport: play/pause/stop transport and tempo generator driving the step sequencer player
module sequencer_transport #(
  parameter int PERIOD_W       = 16,
  parameter int DEFAULT_PERIOD = 1000,
  parameter int MIN_PERIOD     = 250,
  parameter int MAX_PERIOD     = 4000,
  parameter int STEP           = 50
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                play,
  input  logic                stop,
  input  logic                tempo_up,
  input  logic                tempo_down,
  output logic                sequencer_on,
  output logic [2:0]          beat,
  output logic                beat_strobe,
  output logic [PERIOD_W-1:0] period,
  output logic                paused
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [PERIOD_W:0] MIN_W  = (PERIOD_W+1)'(MIN_PERIOD);
  localparam logic [PERIOD_W:0] MAX_W  = (PERIOD_W+1)'(MAX_PERIOD);
  localparam logic [PERIOD_W:0] STEP_W = (PERIOD_W+1)'(STEP);
  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, period_d;
  logic [2:0]          beat_q, beat_d;
  logic                strobe_q, strobe_d, on_q, on_d, paused_q, paused_d;
  logic [PERIOD_W:0]   faster, slower;
  logic                boundary;
  // one guard bit so the saturating compares see true underflow/overflow
  assign faster   = {1'b0, period_q} - STEP_W;
  assign slower   = {1'b0, period_q} + STEP_W;
  // >= rather than == so a period shrunk below the running count still ends the beat next clock
  assign boundary = cnt_q >= period_q - PERIOD_W'(1);
  // tempo update: opposing pulses cancel, otherwise step and clamp
  always_comb begin
    period_d = (tempo_up == tempo_down) ? period_q :
               tempo_up ? ((faster[PERIOD_W] || faster < MIN_W) ? MIN_W[PERIOD_W-1:0] : faster[PERIOD_W-1:0]) :
               ((slower > MAX_W) ? MAX_W[PERIOD_W-1:0] : slower[PERIOD_W-1:0]);
  end
  // transport next state: stop beats play, play beats a beat boundary, beat timing only advances in RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    beat_d   = beat_q;
    strobe_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
      cnt_d   = '0;
      beat_d  = '0;
    end else if (play) begin
      state_d  = (state_q == RUN) ? PAUSE : RUN;
      cnt_d    = (state_q == IDLE) ? '0 : cnt_q;
      beat_d   = (state_q == IDLE) ? '0 : beat_q;
      strobe_d = state_q == IDLE;
    end else if (state_q == RUN) begin
      cnt_d    = boundary ? '0 : cnt_q + PERIOD_W'(1);
      beat_d   = boundary ? beat_q + 3'd1 : beat_q;
      strobe_d = boundary;
    end
    on_d     = state_d == RUN;
    paused_d = state_d == PAUSE;
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      beat_q   <= '0;
      strobe_q <= 1'b0;
      on_q     <= 1'b0;
      paused_q <= 1'b0;
      period_q <= PERIOD_W'(DEFAULT_PERIOD);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      beat_q   <= beat_d;
      strobe_q <= strobe_d;
      on_q     <= on_d;
      paused_q <= paused_d;
      period_q <= period_d;
    end
  end
  assign sequencer_on = on_q;
  assign beat         = beat_q;
  assign beat_strobe  = strobe_q;
  assign period       = period_q;
  assign paused       = paused_q;
endmodule

// File: tb/tb_sequencer_transport.sv
// tb_sequencer_transport: directed checks plus a per-cycle reference model of the transport
module tb_sequencer_transport;
  localparam int PW = 16, DP = 4, MINP = 2, MAXP = 8, ST = 2;
  logic clk = 0, n_rst = 0, play = 0, stop = 0, tempo_up = 0, tempo_down = 0;
  logic sequencer_on, beat_strobe, paused;
  logic [2:0] beat;
  logic [PW-1:0] period;
  int n_vec = 0, n_err = 0;
  int up_exp[3] = '{2, 2, 2};
  int dn_exp[5] = '{4, 6, 8, 8, 8};

  sequencer_transport #(
    .PERIOD_W(PW), .DEFAULT_PERIOD(DP), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .STEP(ST)
  ) dut (
    .clk(clk), .n_rst(n_rst), .play(play), .stop(stop), .tempo_up(tempo_up),
    .tempo_down(tempo_down), .sequencer_on(sequencer_on), .beat(beat),
    .beat_strobe(beat_strobe), .period(period), .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: running/paused flags, clocks elapsed in the current beat, beat number, tempo
  bit m_run = 0, m_pause = 0, m_strobe = 0;
  int m_elapsed = 0, m_beat = 0, m_per = DP;
  always @(posedge clk or negedge n_rst) begin
    int np;
    if (!n_rst) begin
      m_run = 0; m_pause = 0; m_strobe = 0; m_elapsed = 0; m_beat = 0; m_per = DP;
    end else begin
      np = m_per;
      if (tempo_up && !tempo_down) np = (m_per - ST < MINP) ? MINP : m_per - ST;
      if (tempo_down && !tempo_up) np = (m_per + ST > MAXP) ? MAXP : m_per + ST;
      m_strobe = 0;
      if (stop) begin
        m_run = 0; m_pause = 0; m_beat = 0; m_elapsed = 0;
      end else if (play && !m_run && !m_pause) begin
        m_run = 1; m_beat = 0; m_elapsed = 0; m_strobe = 1;
      end else if (play) begin
        m_run = !m_run; m_pause = !m_pause;
      end else if (m_run) begin
        m_elapsed++;
        if (m_elapsed >= m_per) begin
          m_elapsed = 0; m_beat = (m_beat + 1) % 8; m_strobe = 1;
        end
      end
      m_per = np;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (n_rst) begin
      chk("model_on", sequencer_on, m_run);
      chk("model_paused", paused, m_pause);
      chk("model_strobe", beat_strobe, m_strobe);
      chk("model_beat", beat, m_beat);
      chk("model_period", period, m_per);
    end
  end

  initial begin
    cyc(2);
    n_rst = 1;
    cyc(3);
    chk("idle_beat", beat, 0);
    chk("idle_on", sequencer_on, 0);
    chk("idle_strobe", beat_strobe, 0);
    chk("idle_period", period, 4);
    // start: step 0 sounds immediately, then one step every 4 clocks with 7->0 wrap
    play = 1; cyc(1); play = 0;
    chk("start_strobe", beat_strobe, 1);
    chk("start_beat", beat, 0);
    chk("start_on", sequencer_on, 1);
    for (int i = 1; i <= 36; i++) begin
      cyc(1);
      chk("run_strobe", beat_strobe, (i % 4 == 0));
      chk("run_beat", beat, (i / 4) % 8);
      chk("run_on", sequencer_on, 1);
    end
    // pause at count 2 of beat 3, hold, resume, beat 4 two clocks later
    cyc(10);
    chk("pre_pause_beat", beat, 3);
    play = 1; cyc(1); play = 0;
    chk("pause_paused", paused, 1);
    chk("pause_on", sequencer_on, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("hold_beat", beat, 3);
      chk("hold_strobe", beat_strobe, 0);
    end
    play = 1; cyc(1); play = 0;
    chk("resume_on", sequencer_on, 1);
    chk("resume_strobe", beat_strobe, 0);
    cyc(1);
    chk("resume_wait", beat_strobe, 0);
    cyc(1);
    chk("resume_strobe4", beat_strobe, 1);
    chk("resume_beat4", beat, 4);
    // stop and play together at beat 5
    cyc(4);
    chk("beat5", beat, 5);
    stop = 1; play = 1; cyc(1); stop = 0; play = 0;
    chk("stop_beat", beat, 0);
    chk("stop_strobe", beat_strobe, 0);
    chk("stop_on", sequencer_on, 0);
    chk("stop_paused", paused, 0);
    // pause on a beat boundary: the beat does not advance
    play = 1; cyc(1); play = 0;
    cyc(3);
    play = 1; cyc(1); play = 0;
    chk("pause_edge_beat", beat, 0);
    chk("pause_edge_strobe", beat_strobe, 0);
    cyc(5);
    chk("pause_edge_hold", beat, 0);
    stop = 1; cyc(1); stop = 0;
    // stop on a beat boundary: no strobe, beat 0
    play = 1; cyc(1); play = 0;
    cyc(3);
    stop = 1; cyc(1); stop = 0;
    chk("stop_edge_beat", beat, 0);
    chk("stop_edge_strobe", beat_strobe, 0);
    chk("stop_edge_on", sequencer_on, 0);
    // tempo saturation
    for (int k = 0; k < 3; k++) begin
      tempo_up = 1; cyc(1); tempo_up = 0;
      chk("tempo_up", period, up_exp[k]);
      cyc(1);
    end
    for (int k = 0; k < 5; k++) begin
      tempo_down = 1; cyc(1); tempo_down = 0;
      chk("tempo_down", period, dn_exp[k]);
      cyc(1);
    end
    tempo_up = 1; tempo_down = 1; cyc(1); tempo_up = 0; tempo_down = 0;
    chk("tempo_both", period, 8);
    // shrink the period below the running count mid-beat
    play = 1; cyc(1); play = 0;
    cyc(6);
    chk("shrink_pre_strobe", beat_strobe, 0);
    tempo_up = 1; cyc(1);
    chk("shrink_period6", period, 6);
    chk("shrink_mid_strobe", beat_strobe, 0);
    cyc(1); tempo_up = 0;
    chk("shrink_period4", period, 4);
    chk("shrink_strobe", beat_strobe, 1);
    chk("shrink_beat", beat, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      chk("shrink_run_strobe", beat_strobe, (i % 4 == 0));
      chk("shrink_run_beat", beat, 1 + i / 4);
    end
    // asynchronous reset mid-cycle, period changed away from default first
    tempo_down = 1; cyc(1); tempo_down = 0;
    chk("pre_rst_period", period, 6);
    #2 n_rst = 0;
    #1;
    chk("arst_on", sequencer_on, 0);
    chk("arst_beat", beat, 0);
    chk("arst_strobe", beat_strobe, 0);
    chk("arst_paused", paused, 0);
    chk("arst_period", period, 4);
    @(negedge clk);
    n_rst = 1;
    cyc(2);
    chk("post_rst_on", sequencer_on, 0);
    chk("post_rst_period", period, 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sequencer_transport.md
Name: sequencer_transport

Overview:
- Transport and tempo controller for the step sequencer player.
- Generates the 3-bit beat index, a one-cycle beat strobe and the sequencer enable, from user play/stop and tempo pulses.
- Sits between the debounced button/edge-detect logic and the sequencer player. Its beat and sequencer_on outputs drive the player's beat and sequencer_on inputs directly.

Parameters:
- PERIOD_W, 16, width of the tempo period register and the beat-interval counter.
- DEFAULT_PERIOD, 1000, clocks per beat after reset.
- MIN_PERIOD, 250, fastest tempo (smallest period); must be ≥ 2.
- MAX_PERIOD, 4000, slowest tempo (largest period); must fit in PERIOD_W.
- STEP, 50, period change per tempo pulse.

Ports:
- clk  input  1  system clock
- n_rst  input  1  asynchronous active-low reset
- play  input  1  single-cycle pulse; toggles play/pause
- stop  input  1  single-cycle pulse; stop and rewind to beat 0
- tempo_up  input  1  single-cycle pulse; faster (period − STEP)
- tempo_down  input  1  single-cycle pulse; slower (period + STEP)
- sequencer_on  output  1  high only while playing
- beat  output  3  current step index 0–7
- beat_strobe  output  1  one-cycle pulse when a step begins
- period  output  PERIOD_W  current clocks-per-beat value
- paused  output  1  high in PAUSE state

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, beat=0, beat_strobe=0, sequencer_on=0, paused=0.
  - Interval counter=0, period=DEFAULT_PERIOD.
  - Deassertion takes effect on the next clk rising edge.
- FSM states IDLE, RUN, PAUSE. All outputs are registered.
- Transitions:
  - IDLE + play → RUN.
  - RUN + play → PAUSE.
  - PAUSE + play → RUN.
  - Any state + stop → IDLE.
  - stop has priority over a simultaneous play.
- IDLE → RUN (latency 1 clk): next cycle beat=0, counter=0, beat_strobe=1, sequencer_on=1. Step 0 sounds immediately.
- RUN:
  - Counter increments by 1 each clk.
  - When counter ≥ period−1: counter←0, beat←beat+1 (mod 8, 7 wraps to 0), beat_strobe=1 that same cycle.
  - beat_strobe is otherwise 0.
  - Beat interval is exactly `period` clocks.
- RUN → PAUSE:
  - sequencer_on=0 and paused=1 the next cycle.
  - Counter and beat hold.
  - No strobe while paused.
- PAUSE → RUN:
  - Resumes from the held counter and beat.
  - No strobe on resume. The remaining interval completes normally.
- → IDLE:
  - beat=0, counter=0, sequencer_on=0, paused=0 the next cycle.
  - No strobe.
- Tempo:
  - tempo_up: period←max(period−STEP, MIN_PERIOD).
  - tempo_down: period←min(period+STEP, MAX_PERIOD).
  - Saturating; the arithmetic uses a PERIOD_W+1 intermediate, so there is no underflow or overflow.
  - tempo_up and tempo_down in the same cycle: no change.
  - Tempo pulses are accepted in every state and update period the next cycle.
- Tempo change mid-beat:
  - The new period applies immediately.
  - If the counter already ≥ new period−1, the beat advances on the next clk. The ≥ compare makes this safe.
- Simultaneous stop and a beat boundary: stop wins, with no strobe and beat=0.
- Simultaneous play (to PAUSE) and a beat boundary: the pause wins; the beat does not advance.
- Reset mid-operation: everything returns to reset values asynchronously, including period.

Test Plan:
(All scenarios use DEFAULT_PERIOD=4, MIN_PERIOD=2, MAX_PERIOD=8, STEP=2.)
1. Release reset, hold 3 clks idle → beat=0, sequencer_on=0, beat_strobe=0, period=4. Assert n_rst=0 mid-cycle → outputs clear without waiting for clk.
2. play pulse, run 36 clks → strobe on cycle 1 with beat=0, then every 4 clks. Beat sequence 0,1,…,7,0 (7→0 wrap after 32 clks). sequencer_on=1 throughout.
3. Pause/resume: play at counter=2 of beat 3 → paused=1, sequencer_on=0, beat stays 3 for 10 clks with no strobe. play again → beat 4 strobes exactly 2 clks after resume.
4. stop and play in the same cycle during RUN at beat 5 → next cycle state IDLE, beat=0, no strobe.
5. Tempo saturation:
   - 3 tempo_up pulses → period 2, then 2 (saturated).
   - 5 tempo_down pulses → 4, 6, 8, 8, 8.
   - tempo_up and tempo_down together → period unchanged.
6. Tempo shrink mid-beat: period=8, counter=6 → tempo_up ×2 (period 4) → beat advances on the next clk with a strobe. Later intervals are 4 clks.
